// File: rtl/alu_stage.sv
// Execute stage behind the register file: single-cycle ALU ops plus a shift-add MUL,
// producing a one-cycle write-back request and a registered {V, C, Nf, Z} flags word.
module alu_stage #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   dest,
    output logic         busy,
    output logic         done,
    output logic         wb_en,
    output logic [2:0]   wb_sel,
    output logic [N-1:0] wb_data,
    output logic [3:0]   flags
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    localparam logic [SW-1:0] CNT_LAST = SW'(N - 1);
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Single-cycle result: returns {V, C, Nf, Z, r}.
    function automatic logic [N+3:0] alu_fn(input logic [2:0] f_op,
                                            input logic [N-1:0] f_a,
                                            input logic [N-1:0] f_b);
        logic [N:0]   ext;
        logic [N-1:0] r;
        logic         c;
        logic         v;
        ext = {(N+1){1'b0}};
        r   = {N{1'b0}};
        c   = 1'b0;
        v   = 1'b0;
        case (f_op)
            OP_ADD: begin
                ext = {1'b0, f_a} + {1'b0, f_b};
                r   = ext[N-1:0];
                c   = ext[N];
                v   = (f_a[N-1] == f_b[N-1]) && (r[N-1] != f_a[N-1]);
            end
            OP_SUB, OP_CMP: begin
                // Bit N of the widened difference is the borrow (a < b unsigned).
                ext = {1'b0, f_a} - {1'b0, f_b};
                r   = ext[N-1:0];
                c   = ext[N];
                v   = (f_a[N-1] != f_b[N-1]) && (r[N-1] != f_a[N-1]);
            end
            OP_AND: r = f_a & f_b;
            OP_OR:  r = f_a | f_b;
            OP_XOR: r = f_a ^ f_b;
            OP_SHL: begin
                // Bit N catches the last bit shifted out; a zero shift leaves it 0.
                ext = {1'b0, f_a} << f_b[SW-1:0];
                r   = ext[N-1:0];
                c   = ext[N];
            end
            default: r = {N{1'b0}};
        endcase
        return {v, c, r[N-1], (r == {N{1'b0}}), r};
    endfunction

    // MUL flags from the full 2N-bit product: C = V = high half non-zero.
    function automatic logic [3:0] mul_flags(input logic [2*N-1:0] p);
        logic hi;
        hi = (p[2*N-1:N] != {N{1'b0}});
        return {hi, hi, p[N-1], (p[N-1:0] == {N{1'b0}})};
    endfunction

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           wb_en_q, wb_en_d;
    logic [2:0]     wb_sel_q, wb_sel_d;
    logic [N-1:0]   wb_data_q, wb_data_d;
    logic [3:0]     flags_q, flags_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [2:0]     dest_q, dest_d;

    logic [N+3:0]   alu_res_s;
    logic [2*N-1:0] mul_sum_s;

    assign alu_res_s = alu_fn(op, a, b);
    assign mul_sum_s = acc_q + (b_sh_q[0] ? a_sh_q : {(2*N){1'b0}});

    // Next-state and next-output logic for the IDLE/EXEC/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wb_en_d   = 1'b0;
        wb_sel_d  = wb_sel_q;
        wb_data_d = wb_data_q;
        flags_d   = flags_q;
        acc_d     = acc_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        cnt_d     = cnt_q;
        dest_d    = dest_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dest_d = dest;
                    busy_d = 1'b1;
                    if (op == OP_MUL) begin
                        state_d = S_EXEC;
                        acc_d   = {(2*N){1'b0}};
                        a_sh_d  = {{N{1'b0}}, a};
                        b_sh_d  = b;
                        cnt_d   = {SW{1'b0}};
                    end else begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        wb_en_d   = (op != OP_CMP);
                        wb_sel_d  = dest;
                        wb_data_d = alu_res_s[N-1:0];
                        flags_d   = alu_res_s[N+3:N];
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_EXEC: begin
                acc_d  = mul_sum_s;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    wb_en_d   = 1'b1;
                    wb_sel_d  = dest_q;
                    wb_data_d = mul_sum_s[N-1:0];
                    flags_d   = mul_flags(mul_sum_s);
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_sel_q  <= 3'b000;
            wb_data_q <= {N{1'b0}};
            flags_q   <= 4'b0000;
            acc_q     <= {(2*N){1'b0}};
            a_sh_q    <= {(2*N){1'b0}};
            b_sh_q    <= {N{1'b0}};
            cnt_q     <= {SW{1'b0}};
            dest_q    <= 3'b000;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wb_en_q   <= wb_en_d;
            wb_sel_q  <= wb_sel_d;
            wb_data_q <= wb_data_d;
            flags_q   <= flags_d;
            acc_q     <= acc_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            cnt_q     <= cnt_d;
            dest_q    <= dest_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wb_en   = wb_en_q;
    assign wb_sel  = wb_sel_q;
    assign wb_data = wb_data_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_stage;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] dest;
    logic       busy;
    logic       done;
    logic       wb_en;
    logic [2:0] wb_sel;
    logic [7:0] wb_data;
    logic [3:0] flags;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    alu_stage #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .dest(dest),
        .busy(busy), .done(done), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .flags(flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic: {V, C, Nf, Z, r[7:0]}.
    function automatic logic [11:0] model_fn(input logic [2:0] o, input logic [7:0] x,
                                             input logic [7:0] y);
        int ux, uy, sx, sy, full, sfull, r, sh;
        bit c, v;
        logic [7:0] r8;
        ux = int'(x); uy = int'(y);
        sx = int'($signed(x)); sy = int'($signed(y));
        c = 1'b0; v = 1'b0; r = 0; full = 0; sfull = 0;
        case (o)
            3'd0: begin
                full = ux + uy; sfull = sx + sy;
                c = (full > 255); v = (sfull > 127) || (sfull < -128);
                r = full & 255;
            end
            3'd1, 3'd7: begin
                full = ux - uy; sfull = sx - sy;
                c = (ux < uy); v = (sfull > 127) || (sfull < -128);
                r = full & 255;
            end
            3'd2: r = ux & uy;
            3'd3: r = ux | uy;
            3'd4: r = ux ^ uy;
            3'd5: begin
                sh = uy % 8;
                full = ux << sh;
                r = full & 255;
                c = (sh != 0) && (((full >> 8) & 1) == 1);
            end
            default: begin
                full = ux * uy;
                r = full & 255;
                c = (full > 255); v = c;
            end
        endcase
        r8 = r[7:0];
        return {v, c, r8[7], (r8 == 8'h00), r8};
    endfunction

    // Model state, advanced at the same edges the spec defines.
    logic       m_busy = 1'b0, m_done = 1'b0, m_wb_en = 1'b0;
    logic [2:0] m_sel = 3'd0;
    logic [7:0] m_data = 8'h00;
    logic [3:0] m_flags = 4'h0;
    int         m_wait = 0;
    bit         m_in_done = 1'b0;
    logic [11:0] p_res = 12'h000;
    logic        p_wben = 1'b0;
    logic [2:0]  p_sel = 3'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_wb_en <= 1'b0;
            m_sel <= 3'd0; m_data <= 8'h00; m_flags <= 4'h0;
            m_wait <= 0; m_in_done <= 1'b0;
        end else begin
            m_done  <= 1'b0;
            m_wb_en <= 1'b0;
            if (m_in_done) begin
                m_in_done <= 1'b0;
                m_busy    <= 1'b0;
            end else if (m_wait > 1) begin
                m_wait <= m_wait - 1;
            end else if (m_wait == 1) begin
                m_wait <= 0;
                m_done <= 1'b1; m_wb_en <= p_wben; m_sel <= p_sel;
                m_data <= p_res[7:0]; m_flags <= p_res[11:8]; m_in_done <= 1'b1;
            end else if (start) begin
                m_busy <= 1'b1;
                if (op == 3'd6) begin
                    m_wait <= 8;
                    p_res  <= model_fn(op, a, b);
                    p_wben <= 1'b1;
                    p_sel  <= dest;
                end else begin
                    m_done <= 1'b1; m_wb_en <= (op != 3'd7); m_sel <= dest;
                    m_data <= model_fn(op, a, b) & 12'h0FF;
                    m_flags <= model_fn(op, a, b) >> 8;
                    m_in_done <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_wb_en", wb_en, m_wb_en);
            chk("cyc_wb_sel", wb_sel, m_sel);
            chk("cyc_wb_data", wb_data, m_data);
            chk("cyc_flags", flags, m_flags);
        end
    end

    task automatic run_op(input string nm, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [2:0] d, input logic [7:0] e_data,
                          input logic [3:0] e_flags, input logic e_wben, input int e_lat);
        int lat;
        @(posedge clk); #2;
        start = 1'b1; op = o; a = x; b = y; dest = d;
        @(posedge clk); #2;
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_done expected=done_within_20", nm);
        end else begin
            chk({nm, "_lat"}, lat, e_lat);
            chk({nm, "_data"}, wb_data, e_data);
            chk({nm, "_flags"}, flags, e_flags);
            chk({nm, "_wb_en"}, wb_en, e_wben);
            chk({nm, "_wb_sel"}, wb_sel, d);
        end
    endtask

    int dones, wbens, wrong_cyc;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; dest = 3'd0;

        // Pin the reference model itself.
        chk("model_add", model_fn(3'd0, 8'hF0, 8'h20), 12'h410);
        chk("model_sub", model_fn(3'd1, 8'h80, 8'h01), 12'h87F);
        chk("model_shl", model_fn(3'd5, 8'hC1, 8'h0A), 12'h404);
        chk("model_mul", model_fn(3'd6, 8'd16, 8'd16), 12'hD00);

        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_wb_sel", wb_sel, 3'd0);
        chk("rst_wb_data", wb_data, 8'h00);
        chk("rst_flags", flags, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_op("add",    3'd0, 8'hF0, 8'h20, 3'd3, 8'h10, 4'b0100, 1'b1, 1);
        run_op("sub",    3'd1, 8'h80, 8'h01, 3'd1, 8'h7F, 4'b1000, 1'b1, 1);
        run_op("sub_bw", 3'd1, 8'h01, 8'h02, 3'd2, 8'hFF, 4'b0110, 1'b1, 1);
        run_op("cmp",    3'd7, 8'h05, 8'h05, 3'd4, 8'h00, 4'b0001, 1'b0, 1);
        run_op("and",    3'd2, 8'hF0, 8'h3C, 3'd5, 8'h30, 4'b0000, 1'b1, 1);
        run_op("or",     3'd3, 8'h0F, 8'hF0, 3'd6, 8'hFF, 4'b0010, 1'b1, 1);
        run_op("xor",    3'd4, 8'hAA, 8'hAA, 3'd7, 8'h00, 4'b0001, 1'b1, 1);
        run_op("mul1",   3'd6, 8'd15, 8'd17, 3'd1, 8'hFF, 4'b0010, 1'b1, 9);
        run_op("mul2",   3'd6, 8'd16, 8'd16, 3'd2, 8'h00, 4'b1101, 1'b1, 9);
        run_op("shl2",   3'd5, 8'hC1, 8'h0A, 3'd3, 8'h04, 4'b0100, 1'b1, 1);
        run_op("shl0",   3'd5, 8'hC1, 8'h08, 3'd4, 8'hC1, 4'b0010, 1'b1, 1);

        // start held high through a MUL: one done, re-accept only after done.
        @(posedge clk); #2;
        start = 1'b1; op = 3'd6; a = 8'd200; b = 8'd3; dest = 3'd5;
        @(posedge clk); #2;
        op = 3'd0; a = 8'h01; b = 8'h02; dest = 3'd6;
        dones = 0; wbens = 0; wrong_cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (i != 9) wrong_cyc++;
                chk("hold_mul_data", wb_data, 8'h58);
                chk("hold_mul_flags", flags, 4'b1100);
            end
            if (wb_en === 1'b1) wbens++;
        end
        chk("hold_dones", dones, 1);
        chk("hold_wbens", wbens, 1);
        chk("hold_done_cycle", wrong_cyc, 0);
        chk("hold_idle_busy", busy, 1'b0);
        @(negedge clk);
        chk("reaccept_done", done, 1'b1);
        chk("reaccept_data", wb_data, 8'h03);
        chk("reaccept_sel", wb_sel, 3'd6);
        @(posedge clk); #2;
        start = 1'b0;

        // Reset in the middle of a MUL aborts it.
        @(posedge clk); #2;
        start = 1'b1; op = 3'd6; a = 8'd15; b = 8'd17; dest = 3'd2;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_wb_en", wb_en, 1'b0);
        chk("abort_flags", flags, 4'h0);
        chk("abort_wb_data", wb_data, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || wb_en === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);

        run_op("add_post", 3'd0, 8'h7F, 8'h01, 3'd7, 8'h80, 4'b1010, 1'b1, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
